conv_lane_serializer: RTL
=========================

// Module: conv_lane_serializer
// PURPOSE
//   Gathers a parallel bank of convolution lanes and streams it out one sample per beat.
//   It is the read-side counterpart of the lane demux, which scatters serial samples into lanes.
//   It sits after the convolution datapath and drives the result samples to downstream consumers.
//   The downstream interface uses a valid/ready handshake, and the block keeps a lane index with each sample.
// PARAMETERS
//   DATA_W  16  width of one sample
//   LANES   64  number of lanes in the parallel bank
//   IDX_W   6   lane index width, equal to clog2(LANES)
// PORTS
//   clk         in   1              rising-edge clock
//   rst_n       in   1              synchronous reset, active low
//   load_valid  in   1              request to capture par_in
//   load_ready  out  1              high when the block can accept a load (IDLE)
//   load_len    in   IDX_W+1        number of lanes to stream, 1..LANES
//   par_in      in   LANES*DATA_W   lane i is par_in[i*DATA_W +: DATA_W]
//   out_valid   out  1              out_data/out_idx/out_last are valid
//   out_ready   in   1              downstream accepts the current beat
//   out_data    out  DATA_W         current sample
//   out_idx     out  IDX_W          lane number of the current sample
//   out_last    out  1              current beat is the final lane of the burst
//   busy        out  1              high while in STREAM
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge)
//   - State goes to IDLE.
//   - out_valid, out_last and busy go to 0; out_data and out_idx go to 0.
//   - load_ready goes to 1, and the captured bank and length clear to 0.
//   - Reset during STREAM aborts the burst; no further beats are emitted.
//   Registers and handshake
//   - All outputs are registered except load_ready, which equals (state==IDLE).
//   - A load fires when load_valid && load_ready. On that edge the block captures
//     par_in into the internal bank and captures len_eff.
//   - len_eff = min(load_len, LANES).
//   - load_len==0 is ignored: nothing is captured and the state stays IDLE.
//   - A load while busy is not accepted (load_ready=0), and the upstream must hold the request.
//   - par_in may change freely after capture; the streamed data comes only from the captured bank.
//   State machine
//   - IDLE -> STREAM on a fired load with len_eff>=1.
//     On that edge: out_valid<=1, out_idx<=0, out_data<=lane0, out_last<=(len_eff==1).
//   - STREAM, beat accepted (out_valid && out_ready) and not last:
//     idx<=idx+1, out_data<=bank[idx+1], out_last<=(idx+1==len_eff-1).
//   - STREAM, last beat accepted: out_valid, out_last and busy go to 0 and the state returns to IDLE.
//     load_ready is 1 from the next cycle.
//   - STREAM, out_ready=0: out_data, out_idx and out_last hold stable with out_valid=1.
//   Timing and width rules
//   - Latency is 1 cycle from a fired load to the first out_valid.
//   - Throughput is 1 beat per cycle when out_ready is held high.
//   - A burst of N lanes with ready held high takes exactly N valid cycles.
//   - The minimum gap between bursts is 1 cycle: the IDLE cycle in which the next load fires.
//   - out_idx never exceeds len_eff-1, so there is no wrap-around.
//     For LANES=64 the index counts 0..63 within IDX_W bits.
//   - Data passes through bit-exact; there is no arithmetic on samples.
// TESTING
//   1. Full burst: par_in lane i = 16'h1000+i, load_len=64, out_ready=1
//      -> 64 consecutive beats with out_data=16'h1000+idx, out_idx 0..63,
//         out_last only on idx 63, first valid 1 cycle after the load.
//   2. Backpressure: load_len=4, out_ready toggled 1,0,0,1,...
//      -> each beat is held stable while ready=0; the sequence is idx 0..3 with no drops or duplicates.
//   3. Short and edge lengths:
//      - load_len=1 -> a single beat with out_idx=0 and out_last=1.
//      - load_len=0 -> no out_valid, and load_ready stays 1.
//      - load_len=100 -> clamped to a 64-beat burst.
//   4. Load while busy: assert load_valid with new par_in mid-burst
//      -> not accepted; the current burst data is unchanged; the new load fires in the IDLE cycle after out_last.
//   5. Capture isolation: change par_in every cycle after the load fires
//      -> the streamed data equals the values present on the load edge.
//   6. Reset mid-stream: drive rst_n=0 at beat 10 of 64
//      -> the next cycle has out_valid=0, busy=0 and load_ready=1; a new load then starts again at idx 0.

Source files
------------

// File: rtl/conv_lane_serializer.sv
// conv_lane_serializer
// Captures a parallel bank of convolution lanes on a load handshake and
// streams the first len_eff lanes out one sample per beat over valid/ready,
// tagging each sample with its lane index and marking the final beat.
module conv_lane_serializer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 64,
  parameter int unsigned IDX_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [IDX_W:0]          load_len,
  input  logic [LANES*DATA_W-1:0] par_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    busy
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  localparam logic [IDX_W:0] LANES_L = (IDX_W+1)'(LANES);
  localparam logic [IDX_W:0] ONE_L   = (IDX_W+1)'(1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   bank_q [LANES];
  logic [DATA_W-1:0]   bank_d [LANES];
  logic [IDX_W:0]      len_q, len_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;

  logic [IDX_W:0]      len_eff;
  logic [IDX_W-1:0]    idx_inc;

  // Clamp the requested length to the bank size and precompute the next lane index.
  always_comb begin
    len_eff = (load_len > LANES_L) ? LANES_L : load_len;
    idx_inc = idx_q + 1'b1;
  end

  // Next-state and next-output logic for the load/stream handshake.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;

    case (state_q)
      ST_IDLE: begin
        // A zero-length request is dropped without touching the bank.
        if (load_valid && (load_len != '0)) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            bank_d[i] = par_in[i*DATA_W +: DATA_W];
          end
          len_d   = len_eff;
          idx_d   = '0;
          data_d  = par_in[DATA_W-1:0];
          valid_d = 1'b1;
          last_d  = (len_eff == ONE_L);
          busy_d  = 1'b1;
          state_d = ST_STREAM;
        end
      end

      ST_STREAM: begin
        // out_valid is always high here, so acceptance is just out_ready.
        if (out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d  = idx_inc;
            data_d = bank_q[idx_inc];
            last_d = ({1'b0, idx_inc} == (len_q - ONE_L));
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured bank and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      for (int unsigned i = 0; i < LANES; i++) begin
        bank_q[i] <= '0;
      end
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_idx    = idx_q;
  assign out_last   = last_q;
  assign busy       = busy_q;

endmodule
